l1a_smp_tagger: RTL

- Generates the per-sample 44-bit L1A tag word (L1A_SMP_DATA) and its write strobe (L1A_WRT_EN) that the DAQ ring buffer consumes alongside each ADC sample.
- Counts L1As and matched L1As, and opens a SAMP_MAX-sample readout window per matched L1A.
- Tracks concurrently open windows and flags overlaps, so the ring-buffer reader can tell which samples are shared between events.

---
 rtl/l1a_smp_tagger.sv | 133 +++++++++++++
 1 files changed

// File: rtl/l1a_smp_tagger.sv
`default_nettype none
// ============================================================================
// Module   : l1a_smp_tagger
// Purpose  : Builds the 44-bit per-sample L1A tag word for the DAQ ring buffer.
//            It counts L1As and matches, and tracks overlapping readout windows.
// Revision : 1.0  initial release
// ============================================================================
module l1a_smp_tagger #(
    parameter int NWIN = 4
) (
    input  logic        CLK,
    input  logic        RST_RESYNC,
    input  logic [6:0]  SAMP_MAX,
    input  logic        SMP_STRB,
    input  logic        L1A,
    input  logic        L1A_MATCH,
    input  logic        L1A_PHASE,
    output logic [43:0] L1A_SMP_DATA,
    output logic        L1A_WRT_EN,
    output logic        WIN_OVFL,
    output logic        MATCH_LOST
);

    localparam int c_SLOT_W = 7;
    localparam int c_SNAP_W = 37;

    logic [23:0]          r_l1acnt;
    logic [11:0]          r_l1amcnt;
    logic                 r_pend;
    logic [c_SNAP_W-1:0]  r_snap;
    logic [c_SLOT_W-1:0]  r_slot     [NWIN];

    logic [23:0]          w_l1acnt_nxt;
    logic [11:0]          w_l1amcnt_nxt;
    logic                 w_accept;
    logic                 w_lost;
    logic                 w_apply;
    logic [c_SNAP_W-1:0]  w_snap_new;
    logic [c_SNAP_W-1:0]  w_snap_use;
    logic [c_SLOT_W-1:0]  w_load_val;
    logic [c_SLOT_W-1:0]  w_slot_dec [NWIN];
    logic [c_SLOT_W-1:0]  w_slot_nxt [NWIN];
    logic                 w_free_found;
    logic [7:0]           w_nact;
    logic [7:0]           w_nact_m1;
    logic [3:0]           w_ovcnt;
    logic                 w_ovrlap;
    logic                 w_multi;

    assign w_l1acnt_nxt  = r_l1acnt + {23'd0, L1A};
    assign w_l1amcnt_nxt = r_l1amcnt + {11'd0, L1A_MATCH};

    // A second match while one is pending is counted but otherwise dropped.
    assign w_accept   = L1A_MATCH & ~r_pend;
    assign w_lost     = L1A_MATCH & r_pend;
    assign w_apply    = SMP_STRB & (r_pend | w_accept);

    // Snapshot layout matches the upper tag fields: {phase, l1amcnt, l1acnt}.
    assign w_snap_new = {L1A_PHASE, w_l1amcnt_nxt, w_l1acnt_nxt};
    assign w_snap_use = r_pend ? r_snap : w_snap_new;
    assign w_load_val = (SAMP_MAX == '0) ? 7'd1 : SAMP_MAX;

    for (genvar gi = 0; gi < NWIN; gi++) begin : g_slot
        assign w_slot_dec[gi] = (r_slot[gi] != '0) ? r_slot[gi] - 7'd1 : '0;
    end

    // Decrement first so a slot expiring on this strobe can take the new window.
    always_comb begin
        w_slot_nxt   = w_slot_dec;
        w_free_found = 1'b0;
        w_nact       = '0;
        if (w_apply) begin
            for (int i = 0; i < NWIN; i++) begin
                if (!w_free_found && (w_slot_dec[i] == '0)) begin
                    w_slot_nxt[i] = w_load_val;
                    w_free_found  = 1'b1;
                end
            end
        end
        for (int i = 0; i < NWIN; i++) begin
            if (w_slot_nxt[i] != '0) begin
                w_nact = w_nact + 8'd1;
            end
        end
    end

    assign w_nact_m1 = w_nact - 8'd1;
    assign w_ovrlap  = (w_nact >= 8'd2);
    assign w_multi   = (w_nact >= 8'd3);

    always_comb begin
        w_ovcnt = 4'd0;
        if (w_nact >= 8'd17) begin
            w_ovcnt = 4'hF;
        end else if (w_ovrlap) begin
            w_ovcnt = w_nact_m1[3:0];
        end
    end

    always_ff @(posedge CLK or posedge RST_RESYNC) begin
        if (RST_RESYNC) begin
            r_l1acnt     <= '0;
            r_l1amcnt    <= '0;
            r_pend       <= 1'b0;
            r_snap       <= '0;
            for (int i = 0; i < NWIN; i++) begin
                r_slot[i] <= '0;
            end
            L1A_SMP_DATA <= '0;
            L1A_WRT_EN   <= 1'b0;
            WIN_OVFL     <= 1'b0;
            MATCH_LOST   <= 1'b0;
        end else begin
            r_l1acnt   <= w_l1acnt_nxt;
            r_l1amcnt  <= w_l1amcnt_nxt;
            L1A_WRT_EN <= SMP_STRB;
            WIN_OVFL   <= w_apply & ~w_free_found;
            MATCH_LOST <= w_lost;
            if (SMP_STRB) begin
                r_pend       <= 1'b0;
                r_slot       <= w_slot_nxt;
                L1A_SMP_DATA <= {w_multi, w_ovrlap, w_apply & w_snap_use[36], w_apply,
                                 w_ovcnt,
                                 w_apply ? w_snap_use[35:0] : L1A_SMP_DATA[35:0]};
            end else if (w_accept) begin
                r_pend <= 1'b1;
                r_snap <= w_snap_new;
            end
        end
    end

endmodule
`default_nettype wire
